// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and parity-type constants,
// also used by the transmitter's parity calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and frame configuration in, parallel byte and status strobes out.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);
  logic                  RX_IN;
  logic [PRESC_W-1:0]    Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter (0..P-1 per bit) and bit counter for the UART receiver.
module uart_rx_edge_bit_cnt #(
  parameter int PRESC_W = 6,
  parameter int BIT_W   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               bit_end
);

  localparam logic [PRESC_W-1:0] E_ONE = PRESC_W'(1);
  localparam logic [BIT_W-1:0]   B_ONE = BIT_W'(1);

  assign bit_end = run && (edge_cnt == presc - E_ONE);

  // The start-detect cycle itself is edge 0 of the start bit, so counting resumes at 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (start) begin
      edge_cnt <= E_ONE;
      bit_cnt  <= '0;
    end else if (run) begin
      if (bit_end) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + B_ONE;
      end else begin
        edge_cnt <= edge_cnt + E_ONE;
      end
    end else begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start detection, 3-sample majority vote, LSB-first
// deserialisation, optional parity and stop-bit checking with one-cycle strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input logic     CLK,
  input logic     RST,
  uart_rx_if.slave rx
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 4);
  localparam logic [PRESC_W-1:0] E_ONE     = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] E_TWO     = PRESC_W'(2);
  localparam logic [BIT_W-1:0]   LAST_DATA = BIT_W'(DATA_WIDTH);

  rx_state_e             state;
  logic [PRESC_W-1:0]    presc_l;
  logic                  par_en_l;
  logic                  par_typ_l;
  logic [PRESC_W-1:0]    edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  bit_end;
  logic [PRESC_W-1:0]    half;
  logic                  start_det;
  logic                  running;
  logic                  in_window;
  logic                  decide;
  logic [2:0]            samp;
  logic                  maj;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  exp_par;
  logic                  frame_bad;
  logic                  stop_ok;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic                  data_valid_r;
  logic                  par_err_r;
  logic                  stp_err_r;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  assign half      = presc_l >> 1;
  assign start_det = (state == ST_IDLE) && !rx.RX_IN;
  assign running   = (state != ST_IDLE);
  assign in_window = running && (edge_cnt >= half - E_ONE) && (edge_cnt <= half + E_ONE);
  assign decide    = running && (edge_cnt == half + E_TWO);
  assign maj       = maj3(samp);
  assign exp_par   = (^shift_reg) ^ (par_typ_l == PAR_ODD);

  uart_rx_edge_bit_cnt #(
    .PRESC_W (PRESC_W),
    .BIT_W   (BIT_W)
  ) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start_det),
    .run      (running),
    .presc    (presc_l),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  // Sampler and deserialiser: pure datapath, no reset needed.
  always_ff @(posedge CLK) begin
    if (in_window)
      samp <= {samp[1:0], rx.RX_IN};
    if (decide && (state == ST_DATA))
      shift_reg <= {maj, shift_reg[DATA_WIDTH-1:1]};
  end

  // Frame control: configuration is captured only when leaving IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= ST_IDLE;
      presc_l      <= '0;
      par_en_l     <= 1'b0;
      par_typ_l    <= 1'b0;
      frame_bad    <= 1'b0;
      stop_ok      <= 1'b0;
      p_data_r     <= '0;
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx.RX_IN) begin
            state     <= ST_START;
            presc_l   <= rx.Prescale;
            par_en_l  <= rx.PAR_EN;
            par_typ_l <= rx.PAR_TYP;
            frame_bad <= 1'b0;
            stop_ok   <= 1'b0;
          end
        end
        ST_START: begin
          if (decide && maj)
            state <= ST_IDLE;
          else if (bit_end)
            state <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_end && (bit_cnt == LAST_DATA))
            state <= par_en_l ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (decide && (maj != exp_par)) begin
            par_err_r <= 1'b1;
            frame_bad <= 1'b1;
          end
          if (bit_end)
            state <= ST_STOP;
        end
        ST_STOP: begin
          if (decide) begin
            stop_ok   <= maj;
            stp_err_r <= !maj;
          end
          if (bit_end) begin
            if (stop_ok && !frame_bad) begin
              p_data_r     <= shift_reg;
              data_valid_r <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rx.P_DATA     = p_data_r;
  assign rx.data_valid = data_valid_r;
  assign rx.par_err    = par_err_r;
  assign rx.stp_err    = stp_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx; a frame-level model predicts strobes,
// their cycle positions and the held parallel byte.
module tb_uart_rx;

  localparam int DW = 8;
  localparam int PW = 6;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_rx_if #(.DATA_WIDTH(DW), .PRESC_W(PW)) rxif ();

  uart_rx #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .CLK (CLK),
    .RST (RST),
    .rx  (rxif)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  int            v_cyc_q[$];
  logic [DW-1:0] v_dat_q[$];
  int            pe_q[$];
  int            se_q[$];
  logic [DW-1:0] model_pdata = '0;

  // Event recorder: every strobe seen, with the cycle it was visible in.
  always @(negedge CLK) begin
    if (rxif.data_valid === 1'b1) begin
      v_cyc_q.push_back(cyc);
      v_dat_q.push_back(rxif.P_DATA);
    end
    if (rxif.par_err === 1'b1) pe_q.push_back(cyc);
    if (rxif.stp_err === 1'b1) se_q.push_back(cyc);
    if (RST && !(rxif.Prescale inside {6'd8, 6'd16, 6'd32}))
      $error("FAIL prescale_range observed %0d required 8/16/32", rxif.Prescale);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout required completion");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic flush_events();
    v_cyc_q.delete();
    v_dat_q.delete();
    pe_q.delete();
    se_q.delete();
  endtask

  // Parity bit that makes the total count of ones even (pt=0) or odd (pt=1).
  function automatic bit good_par(input logic [DW-1:0] d, input bit pt);
    return bit'(($countones(d) + int'(pt)) % 2);
  endfunction

  // Must be called on a falling edge; t0 is the cycle number in which the start bit is driven.
  task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pe, input bit pt,
                            input bit par_bit, input bit stop_b, input bit scramble,
                            output int t0);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(par_bit);
    bits.push_back(stop_b);
    rxif.Prescale = PW'(p);
    rxif.PAR_EN   = pe;
    rxif.PAR_TYP  = pt;
    t0 = cyc;
    foreach (bits[k]) begin
      rxif.RX_IN = bits[k];
      for (int c = 0; c < p; c++) begin
        @(negedge CLK);
        if (scramble && k == 0 && c == 0) begin
          rxif.Prescale = (p == 8) ? 6'd32 : 6'd8;
          rxif.PAR_EN   = !pe;
          rxif.PAR_TYP  = !pt;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [DW-1:0] d, input int p, input bit pe,
                             input bit pt, input bit par_bit, input bit stop_b, input int t0);
    int nb;
    bit par_ok;
    bit exp_v;
    nb     = 2 + DW + int'(pe);
    par_ok = !pe || ((($countones(d) + int'(par_bit)) % 2) == int'(pt));
    exp_v  = par_ok && stop_b;
    check({tag, "_valid_cnt"}, v_cyc_q.size(), exp_v);
    if (exp_v && v_cyc_q.size() > 0) begin
      check({tag, "_valid_cyc"}, v_cyc_q[0] - t0, nb * p);
      check({tag, "_valid_data"}, v_dat_q[0], d);
    end
    check({tag, "_perr_cnt"}, pe_q.size(), pe && !par_ok);
    if (pe && !par_ok && pe_q.size() > 0)
      check({tag, "_perr_cyc"}, pe_q[0] - t0, 1 + (1 + DW) * p + p / 2 + 2);
    check({tag, "_serr_cnt"}, se_q.size(), !stop_b);
    if (!stop_b && se_q.size() > 0)
      check({tag, "_serr_cyc"}, se_q[0] - t0, 1 + (nb - 1) * p + p / 2 + 2);
    if (exp_v) model_pdata = d;
    check({tag, "_p_data"}, rxif.P_DATA, model_pdata);
    flush_events();
  endtask

  task automatic run_frame(input string tag, input logic [DW-1:0] d, input int p, input bit pe,
                           input bit pt, input bit par_bit, input bit stop_b, input bit scramble);
    int t0;
    send_frame(d, p, pe, pt, par_bit, stop_b, scramble, t0);
    rxif.RX_IN = 1'b1;
    tick(3);
    #1;
    check_frame(tag, d, p, pe, pt, par_bit, stop_b, t0);
    @(negedge CLK);
  endtask

  initial begin
    int t0a, t0b, p;
    logic [DW-1:0] d;
    bit pe, pt, pb, sb, scr;
    int kind;

    rxif.RX_IN    = 1'b1;
    rxif.Prescale = 6'd8;
    rxif.PAR_EN   = 1'b0;
    rxif.PAR_TYP  = 1'b0;
    RST           = 1'b0;

    // Reset values
    tick(2);
    #1;
    check("rst_p_data", rxif.P_DATA, 0);
    check("rst_valid", rxif.data_valid, 0);
    check("rst_par_err", rxif.par_err, 0);
    check("rst_stp_err", rxif.stp_err, 0);
    @(negedge CLK);
    RST = 1'b1;
    tick(3);
    flush_events();

    // 1: P=8, no parity, 0xA5, valid at 80 cycles
    run_frame("t1", 8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 2: P=16 even parity, good then flipped parity bit
    run_frame("t2a", 8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame("t2b", 8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // 3: P=32, stop bit low
    run_frame("t3", 8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: short low glitch in idle, then a real frame
    rxif.Prescale = 6'd16;
    rxif.PAR_EN   = 1'b0;
    rxif.RX_IN    = 1'b0;
    tick(4);
    rxif.RX_IN = 1'b1;
    tick(32);
    #1;
    check("t4_glitch_valid", v_cyc_q.size(), 0);
    check("t4_glitch_perr", pe_q.size(), 0);
    check("t4_glitch_serr", se_q.size(), 0);
    flush_events();
    @(negedge CLK);
    run_frame("t4", 8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 5: back-to-back frames, no idle gap
    send_frame(8'h01, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0a);
    send_frame(8'hFE, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0b);
    rxif.RX_IN = 1'b1;
    tick(3);
    #1;
    check("t5_valid_cnt", v_cyc_q.size(), 2);
    if (v_cyc_q.size() == 2) begin
      check("t5_first_cyc", v_cyc_q[0] - t0a, 160);
      check("t5_spacing", v_cyc_q[1] - v_cyc_q[0], 160);
      check("t5_data0", v_dat_q[0], 8'h01);
      check("t5_data1", v_dat_q[1], 8'hFE);
    end
    check("t5_errs", pe_q.size() + se_q.size(), 0);
    model_pdata = 8'hFE;
    check("t5_p_data", rxif.P_DATA, model_pdata);
    flush_events();
    @(negedge CLK);

    // 6: reset in the middle of the data bits
    rxif.Prescale = 6'd8;
    rxif.PAR_EN   = 1'b0;
    rxif.RX_IN    = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      rxif.RX_IN = i[0];
      tick(8);
    end
    RST = 1'b0;
    #1;
    check("t6_rst_p_data", rxif.P_DATA, 0);
    check("t6_rst_valid", rxif.data_valid, 0);
    check("t6_rst_perr", rxif.par_err, 0);
    check("t6_rst_serr", rxif.stp_err, 0);
    rxif.RX_IN = 1'b1;
    tick(4);
    RST = 1'b1;
    tick(100);
    #1;
    check("t6_no_strobe", v_cyc_q.size() + pe_q.size() + se_q.size(), 0);
    model_pdata = '0;
    check("t6_p_data_held", rxif.P_DATA, model_pdata);
    flush_events();
    @(negedge CLK);
    run_frame("t6", 8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized frames, including mid-frame configuration changes
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      d    = DW'($urandom);
      pe   = bit'($urandom_range(0, 1));
      pt   = bit'($urandom_range(0, 1));
      scr  = bit'($urandom_range(0, 1));
      kind = $urandom_range(0, 5);
      pb   = good_par(d, pt) ^ (kind == 0);
      sb   = (kind != 1);
      if (kind == 2) begin
        pb = !good_par(d, pt);
        sb = 1'b0;
      end
      run_frame($sformatf("rnd%0d", n), d, p, pe, pt, pb, sb, scr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
